// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, converter state type and segment decoder
package display_pkg;

  localparam int BIN_W      = 12;
  localparam int BCD_W      = 16;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_e;

  // Active-low gfedcba; codes above 9 never occur and show blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    logic [6:0] s;
    case (nibble)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter, one bit per cycle
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             busy,
  output logic             done
);

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] shift_bin_q, shift_bin_d;
  logic [BCD_W-1:0] scratch_q, scratch_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] adj;
  logic [3:0]       iter_q, iter_d;

  always_comb begin
    state_d     = state_q;
    shift_bin_d = shift_bin_q;
    scratch_d   = scratch_q;
    bcd_d       = bcd_q;
    iter_d      = iter_q;
    adj         = scratch_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_bin_d = bin;
          scratch_d   = '0;
          iter_d      = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, shift_bin_d} = {adj, shift_bin_q} << 1;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd11) state_d = DONE;
      end
      DONE: begin
        bcd_d   = scratch_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_bin_q <= '0;
      scratch_q   <= '0;
      bcd_q       <= '0;
      iter_q      <= '0;
    end else begin
      state_q     <= state_d;
      shift_bin_q <= shift_bin_d;
      scratch_q   <= scratch_d;
      bcd_q       <= bcd_d;
      iter_q      <= iter_d;
    end
  end

  assign bcd  = bcd_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: rtl/display_control.sv
// rtl/display_control.sv - change-driven BCD conversion and multiplexed 7-segment drive
module display_control
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 27000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] acumulador,
  output logic [15:0] bcd,
  output logic        busy,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [BIN_W-1:0] last_val_q, last_val_d;
  logic [BIN_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [BCD_W-1:0] bcd_w;
  logic             start, conv_busy, conv_done, blank;
  logic [3:0]       nib;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (acumulador),
    .bcd   (bcd_w),
    .busy  (conv_busy),
    .done  (conv_done)
  );

  always_comb begin
    // last_val only advances on commit, so an input that moved mid-conversion retriggers.
    start      = !conv_busy && (acumulador != last_val_q);
    last_val_d = last_val_q;
    pend_d     = pend_q;
    if (start) pend_d = acumulador;
    if (conv_done) last_val_d = pend_q;

    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end

    nib   = bcd_w[4*idx_q +: 4];
    blank = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx_q) && bcd_w[4*i +: 4] != 4'd0) blank = 1'b0;
    end
    if (idx_q == 2'd0) blank = 1'b0;
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? SEG_BLANK : bcd_to_seg(nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_val_q <= '0;
      pend_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      an_q       <= 4'b1110;
      seg_q      <= 7'h40;
    end else begin
      last_val_q <= last_val_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign bcd  = bcd_w;
  assign busy = conv_busy;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule
